plus_raster_irq: RTL and testbench
==================================

# plus_raster_irq

Plus-mode raster interrupt and split-screen sequencer for the Amstrad motherboard. Counts CRTC scanlines from HSYNC/VSYNC and raises a Programmable Raster Interrupt (PRI) into the CPU interrupt line, where it is wired-AND with the gate-array interrupt. It supplies the IM2 vector from the Interrupt Vector Register (IVR) during acknowledge. It also emits split-screen reload and soft-scroll values for the video address path. It sits between the ASIC register decode, which sources writes at &6800–&6805, and the CPU `INT_n` / CRTC address stage.

## Interface
Parameters: none.

Ports:
- `clk` in 1: system clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `asic_wr` in 1: one-clk write strobe for an ASIC register; already qualified by ASIC unlock and page mapping.
- `asic_addr` in 3: register offset. 0 = PRI, 1 = SSCR (split line), 2 = SSA high, 3 = SSA low, 4 = soft scroll, 5 = IVR. Offsets 6–7 are ignored.
- `asic_din` in 8: write data.
- `hsync_i` in 1: CRTC HSYNC, level.
- `vsync_i` in 1: CRTC VSYNC, level.
- `int_ack` in 1: level, high while the CPU is in an interrupt-acknowledge cycle (M1 and IORQ both active).
- `int_n` out 1: active-low interrupt request.
- `pri_mode` out 1: high when PRI ≠ 0. The gate array suppresses its 52-line interrupt while this is high.
- `ivr_out` out 8: vector value.
- `ivr_oe` out 1: high while `ivr_out` must drive the CPU data bus.
- `split_load` out 1: one-clk pulse requesting an MA reload to `split_addr`.
- `split_addr` out 14: split start address.
- `scroll` out 8: soft-scroll register.

## Operation
- Edge detect:
  - `h_d` and `v_d` are the previous-clk copies of `hsync_i` and `vsync_i`.
  - `hfall` = `h_d & ~hsync_i`.
  - `vrise` = `~v_d & vsync_i`.
- Line counter `lc` (8 bit):
  - On `vrise`: `lc` ← 0. This has priority over `hfall` in the same clk.
  - Else on `hfall`: `lc` ← `lc` + 1, wrapping 255 → 0.
  - `lc_next` is the combinational value being loaded.
- PRI match: when `hfall & ~vrise & (lc_next == PRI) & (PRI != 0)`, set `pending`.
  - Compare uses the PRI value held before any same-clk write.
  - `int_n` = `~pending`.
- Acknowledge, on the rising edge of `int_ack` with `pending` = 1:
  - Clear `pending`.
  - If IVR[0] = 0, set `ivr_oe`. It stays high until `int_ack` goes low, then clears on the next clk.
  - If IVR[0] = 1 (IM1 style), `ivr_oe` stays 0.
  - An ack rising edge with `pending` = 0 has no effect.
- `ivr_out` = {IVR[7:3], 2'b11, 1'b0}. Source code 11 identifies the raster interrupt.
- Register writes:
  - Writing PRI (any value) clears `pending`.
  - SSA high uses bits [5:0] → `split_addr[13:8]`; bits [7:6] are ignored.
  - SSA low → `split_addr[7:0]`.
- Split: when `hfall & ~vrise & (lc_next == SSCR) & (SSCR != 0)`, pulse `split_load` for one clk.
- Simultaneous events:
  - PRI match and ack rising edge in the same clk: the match wins and `pending` stays 1. `ivr_oe` is still set per the ack rule.
  - PRI write and match in the same clk: the match sets `pending`, and the write-clear is applied first, so the result is `pending` = 1.
- Reset values:
  - `lc` = 0, PRI = 0, SSCR = 0, SSA = 0, scroll = 0, IVR = 8'h01.
  - `pending` = 0, `h_d` = `v_d` = 0.
  - Outputs: `int_n` = 1, `ivr_oe` = 0, `split_load` = 0, `pri_mode` = 0.
  - Reset asserted mid-frame or mid-ack forces all of these on the next edge.

## Timing
- `hfall` is detected in clk N (the first clk where `hsync_i` = 0 after a 1). `lc`, `pending` and `split_load` update at the end of N. `int_n` is low from N+1, i.e. 1-clk latency from the sampled HSYNC fall.
- `vrise` in clk N gives `lc` = 0 from N+1.
- A register write at clk N is visible on its output (`scroll`, `split_addr`, `pri_mode`) from N+1.
- `int_ack` rising at clk N gives `int_n` = 1 and `ivr_oe` = 1 from N+1.
- `ivr_oe` falls one clk after `int_ack` falls.
- `split_load` is exactly 1 clk wide, coincident with the `lc` update.
- No back-pressure. An ack that never arrives leaves `int_n` low indefinitely, and further matches are idempotent.

## Test plan
- After reset: `int_n` = 1, `ivr_oe` = 0, `pri_mode` = 0, `ivr_out` = 8'h06, `scroll` = 0.
- Write PRI = 8'd10, pulse VSYNC, then 10 HSYNC pulses → `int_n` falls exactly one clk after the 10th HSYNC fall and not before. `pri_mode` = 1.
- With IVR = 8'h40 and `pending` set: raise `int_ack` for 3 clks → `ivr_oe` is high for clks 2–4 with `ivr_out` = 8'h46, and `int_n` = 1 from clk 2. Repeat with IVR = 8'h41 → `ivr_oe` stays 0 and `int_n` still clears.
- SSCR = 8'd5, SSA = 14'h2A55 (write 8'hEA to offset 2) → `split_addr` = 14'h2A55, and `split_load` is a single 1-clk pulse after the 5th HSYNC fall following VSYNC.
- Edge cases:
  - VSYNC rise and HSYNC fall in the same clk → `lc` = 0 and no match with PRI = 1.
  - 256 HSYNCs without VSYNC → `lc` wraps and PRI = 3 matches again on the 259th HSYNC.
  - PRI write while `pending` → `int_n` = 1 next clk.
- Ack rising edge in the same clk as a new PRI match → `int_n` stays low. Reset asserted while `int_n` is low → `int_n` = 1, `lc` = 0 next clk.

Source files
------------

// File: rtl/plus_raster_irq.sv
// plus_raster_irq: Plus raster interrupt (PRI), IM2 vector supply and split-screen/soft-scroll sequencer
module plus_raster_irq (
  input  logic        clk,
  input  logic        reset,
  input  logic        asic_wr,
  input  logic [2:0]  asic_addr,
  input  logic [7:0]  asic_din,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        int_ack,
  output logic        int_n,
  output logic        pri_mode,
  output logic [7:0]  ivr_out,
  output logic        ivr_oe,
  output logic        split_load,
  output logic [13:0] split_addr,
  output logic [7:0]  scroll
);
  logic       h_d, v_d, ack_d, pending;
  logic [7:0] lc, lc_next, pri, sscr, ivr;
  logic       hfall, vrise, ack_rise, pri_hit, split_hit;
  logic       wr_pri, wr_sscr, wr_ssah, wr_ssal, wr_scroll, wr_ivr;
  always_comb begin
    hfall     = h_d & ~hsync_i;
    vrise     = ~v_d & vsync_i;
    ack_rise  = int_ack & ~ack_d;
    lc_next   = vrise ? 8'd0 : hfall ? lc + 8'd1 : lc;
    pri_hit   = hfall & ~vrise & (lc_next == pri) & (pri != 8'd0);
    split_hit = hfall & ~vrise & (lc_next == sscr) & (sscr != 8'd0);
    wr_pri    = asic_wr & (asic_addr == 3'd0);
    wr_sscr   = asic_wr & (asic_addr == 3'd1);
    wr_ssah   = asic_wr & (asic_addr == 3'd2);
    wr_ssal   = asic_wr & (asic_addr == 3'd3);
    wr_scroll = asic_wr & (asic_addr == 3'd4);
    wr_ivr    = asic_wr & (asic_addr == 3'd5);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      h_d        <= 1'b0;
      v_d        <= 1'b0;
      ack_d      <= 1'b0;
      lc         <= 8'd0;
      pending    <= 1'b0;
      ivr_oe     <= 1'b0;
      split_load <= 1'b0;
      pri        <= 8'd0;
      sscr       <= 8'd0;
      split_addr <= 14'd0;
      scroll     <= 8'd0;
      ivr        <= 8'h01;
    end else begin
      h_d        <= hsync_i;
      v_d        <= vsync_i;
      ack_d      <= int_ack;
      lc         <= lc_next;
      pending    <= pri_hit | (pending & ~wr_pri & ~ack_rise);
      ivr_oe     <= (ack_rise & pending & ~ivr[0]) | (ivr_oe & int_ack);
      split_load <= split_hit;
      pri        <= wr_pri ? asic_din : pri;
      sscr       <= wr_sscr ? asic_din : sscr;
      split_addr <= wr_ssah ? {asic_din[5:0], split_addr[7:0]} :
                    wr_ssal ? {split_addr[13:8], asic_din} : split_addr;
      scroll     <= wr_scroll ? asic_din : scroll;
      ivr        <= wr_ivr ? asic_din : ivr;
    end
  end
  always_comb begin
    int_n    = ~pending;
    pri_mode = pri != 8'd0;
    ivr_out  = {ivr[7:3], 3'b110};
  end
endmodule

// File: tb/tb_plus_raster_irq.sv
// tb_plus_raster_irq: scoreboard bench with a frame/line reference model for plus_raster_irq
module tb_plus_raster_irq;
  logic        clk = 1'b0, reset = 1'b0, asic_wr = 1'b0;
  logic [2:0]  asic_addr = 3'd0;
  logic [7:0]  asic_din = 8'd0;
  logic        hsync_i = 1'b0, vsync_i = 1'b0, int_ack = 1'b0;
  logic        int_n, pri_mode, ivr_oe, split_load;
  logic [7:0]  ivr_out, scroll;
  logic [13:0] split_addr;

  plus_raster_irq dut (
    .clk(clk), .reset(reset), .asic_wr(asic_wr), .asic_addr(asic_addr), .asic_din(asic_din),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .int_ack(int_ack), .int_n(int_n), .pri_mode(pri_mode),
    .ivr_out(ivr_out), .ivr_oe(ivr_oe), .split_load(split_load), .split_addr(split_addr), .scroll(scroll)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic        int_n, oe, sl, pm;
    logic [7:0]  ivo, scr;
    logic [13:0] sa;
  } exp_t;
  exp_t q[$];
  exp_t e;

  int checks = 0, errors = 0;

  // Reference: line number = HSYNC falls since the last VSYNC rise, modulo 256.
  int          line;
  logic [7:0]  m_pri, m_sscr, m_scroll, m_ivr;
  logic [13:0] m_ssa;
  logic        m_irq, m_oe, m_split, last_h, last_v, last_a;
  logic        hl = 1'b0, vl = 1'b0, al = 1'b0;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d actual %0h required %0h", n, cyc, act, req);
    end
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("int_n", 32'(int_n), 32'(e.int_n));
      chk("ivr_oe", 32'(ivr_oe), 32'(e.oe));
      chk("split_load", 32'(split_load), 32'(e.sl));
      chk("pri_mode", 32'(pri_mode), 32'(e.pm));
      chk("ivr_out", 32'(ivr_out), 32'(e.ivo));
      chk("scroll", 32'(scroll), 32'(e.scr));
      chk("split_addr", 32'(split_addr), 32'(e.sa));
    end
  end

  task automatic step(input logic hs, vs, ack, wr, input logic [2:0] ad, input logic [7:0] d, input logic rs);
    bit fall, frame, ack_edge, new_line, irq_line, split_line;
    exp_t x;
    @(posedge clk); #1;
    hsync_i = hs; vsync_i = vs; int_ack = ack; asic_wr = wr; asic_addr = ad; asic_din = d; reset = rs;
    if (rs) begin
      line = 0; m_pri = 0; m_sscr = 0; m_ssa = 0; m_scroll = 0; m_ivr = 8'h01;
      m_irq = 0; m_oe = 0; m_split = 0; last_h = 0; last_v = 0; last_a = 0;
    end else begin
      fall     = last_h && !hs;
      frame    = !last_v && vs;
      ack_edge = ack && !last_a;
      new_line = fall && !frame;
      if (frame) line = 0;
      else if (fall) line = (line + 1) % 256;
      irq_line   = new_line && m_pri != 0 && line == int'(m_pri);
      split_line = new_line && m_sscr != 0 && line == int'(m_sscr);
      if (ack_edge && m_irq && !m_ivr[0]) m_oe = 1;
      else if (!ack) m_oe = 0;
      if (irq_line) m_irq = 1;
      else if ((wr && ad == 0) || (ack_edge && m_irq)) m_irq = 0;
      m_split = split_line;
      if (wr) begin
        if (ad == 0) m_pri = d;
        if (ad == 1) m_sscr = d;
        if (ad == 2) m_ssa[13:8] = d[5:0];
        if (ad == 3) m_ssa[7:0] = d;
        if (ad == 4) m_scroll = d;
        if (ad == 5) m_ivr = d;
      end
      last_h = hs; last_v = vs; last_a = ack;
    end
    x.due = cyc + 1; x.int_n = !m_irq; x.oe = m_oe; x.sl = m_split; x.pm = m_pri != 0;
    x.ivo = {m_ivr[7:3], 3'b110}; x.scr = m_scroll; x.sa = m_ssa;
    q.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) step(hl, vl, al, 1'b0, 3'd0, 8'd0, 1'b0);
  endtask
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    step(hl, vl, al, 1'b1, a, d, 1'b0);
  endtask
  task automatic rst();
    repeat (2) step(hl, vl, al, 1'b0, 3'd0, 8'd0, 1'b1);
  endtask
  task automatic hpulse(input int n);
    repeat (n) begin hl = 1; idle(2); hl = 0; idle(2); end
  endtask
  task automatic vpulse();
    vl = 1; idle(2); vl = 0; idle(1);
  endtask
  task automatic ack(input int n);
    al = 1; idle(n); al = 0; idle(2);
  endtask

  initial begin
    rst(); idle(2);
    wr(0, 8'd10); vpulse(); hpulse(10); idle(2);
    wr(5, 8'h40); ack(3);
    vpulse(); hpulse(10); wr(5, 8'h41); ack(3);
    wr(5, 8'h40);
    wr(1, 8'd5); wr(2, 8'hEA); wr(3, 8'h55); vpulse(); hpulse(6);
    wr(0, 8'd1); hl = 1; idle(2); hl = 0; vl = 1; idle(1); vl = 0; idle(2); hpulse(1);
    wr(0, 8'd3); wr(1, 8'd0); vpulse(); hpulse(3); ack(1); hpulse(256); ack(1);
    wr(0, 8'd2); vpulse(); hpulse(2); wr(0, 8'd2); idle(2);
    wr(0, 8'd1); vpulse(); hpulse(1); vpulse(); hl = 1; idle(2);
    hl = 0; al = 1; idle(2); al = 0; idle(2);
    vpulse(); hpulse(1); rst(); idle(2); hpulse(1);
    for (int i = 0; i < 2500; i++) begin
      logic [2:0] a;
      logic [7:0] d;
      if ($urandom_range(0, 2) == 0) hl = ~hl;
      if ($urandom_range(0, 40) == 0) vl = ~vl;
      if ($urandom_range(0, 9) == 0) al = ~al;
      a = 3'($urandom_range(0, 7));
      d = (a <= 3'd1) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      step(hl, vl, al, $urandom_range(0, 5) == 0, a, d, $urandom_range(0, 400) == 0);
    end
    idle(2);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual %0d pending entries required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
